// File: rtl/i2c_slave_mem.sv
// I2C responder emulating a 24Cxx-style EEPROM: byte/page write, random,
// current-address and sequential read over an internal auto-incrementing pointer.
module i2c_slave_mem #(
  parameter logic [6:0]  SLAVE_ADDR = 7'b101_0000,
  parameter int unsigned MEM_AW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  inout  wire               sda,
  input  logic              bit_ctrl,
  output logic              busy,
  output logic              wr_strobe,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK,
    WR, WR_ACK, RD, RD_ACK, WAIT_STOP
  } state_t;

  localparam logic [MEM_AW-1:0] PTR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  // [0] metastability stage, [1] synchronised level, [2] previous level
  logic [2:0] scl_pipe_reg, sda_pipe_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe_reg <= 3'b111;
      sda_pipe_reg <= 3'b111;
    end else begin
      scl_pipe_reg <= {scl_pipe_reg[1:0], scl};
      sda_pipe_reg <= {sda_pipe_reg[1:0], sda};
    end
  end

  logic scl_sync, scl_prev, sda_sync, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_sync  = scl_pipe_reg[1];
  assign scl_prev  = scl_pipe_reg[2];
  assign sda_sync  = sda_pipe_reg[1];
  assign sda_prev  = sda_pipe_reg[2];
  assign scl_rise  =  scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync &  scl_prev;
  assign start_det = scl_sync & scl_prev &  sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev &  sda_sync;

  state_t            state_reg, state_next;
  logic [2:0]        bit_cnt_reg, bit_cnt_next;
  logic [7:0]        shift_reg, shift_next;
  logic [7:0]        addr_hi_reg, addr_hi_next;
  logic [MEM_AW-1:0] ptr_reg, ptr_next;
  logic              bit_ctrl_reg, bit_ctrl_next;
  logic              rw_reg, rw_next;
  logic              ack_phase_reg, ack_phase_next;
  logic              sda_drv_reg, sda_drv_next;
  logic              busy_reg, busy_next;
  logic              wr_strobe_reg, wr_strobe_next;
  logic [MEM_AW-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]        wr_data_reg, wr_data_next;

  logic [7:0]        mem [0:(1<<MEM_AW)-1];
  logic [7:0]        rd_data_reg;
  logic              mem_we;
  logic [7:0]        byte_in;
  logic [15:0]       word_addr;

  // Memory is deliberately not reset; the read port tracks the pointer every clk
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ptr_reg] <= byte_in;
    end
    rd_data_reg <= mem[ptr_reg];
  end

  assign byte_in   = {shift_reg[6:0], sda_sync};
  assign word_addr = bit_ctrl_reg ? {addr_hi_reg, byte_in} : {8'h00, byte_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      addr_hi_reg   <= 8'h00;
      ptr_reg       <= '0;
      bit_ctrl_reg  <= 1'b0;
      rw_reg        <= 1'b0;
      ack_phase_reg <= 1'b0;
      sda_drv_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= 8'h00;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      addr_hi_reg   <= addr_hi_next;
      ptr_reg       <= ptr_next;
      bit_ctrl_reg  <= bit_ctrl_next;
      rw_reg        <= rw_next;
      ack_phase_reg <= ack_phase_next;
      sda_drv_reg   <= sda_drv_next;
      busy_reg      <= busy_next;
      wr_strobe_reg <= wr_strobe_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    addr_hi_next   = addr_hi_reg;
    ptr_next       = ptr_reg;
    bit_ctrl_next  = bit_ctrl_reg;
    rw_next        = rw_reg;
    ack_phase_next = ack_phase_reg;
    sda_drv_next   = sda_drv_reg;
    busy_next      = busy_reg;
    wr_strobe_next = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    mem_we         = 1'b0;

    // Bus conditions win over any bit handling in the same clk
    if (start_det) begin
      state_next     = DEV;
      bit_cnt_next   = 3'd0;
      sda_drv_next   = 1'b0;
      ack_phase_next = 1'b0;
      bit_ctrl_next  = bit_ctrl;
    end else if (stop_det) begin
      state_next     = IDLE;
      sda_drv_next   = 1'b0;
      busy_next      = 1'b0;
      ack_phase_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE, WAIT_STOP: begin
          sda_drv_next = 1'b0;
        end

        DEV, AHI, ALO, WR: begin
          if (scl_rise) begin
            shift_next   = byte_in;
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              ack_phase_next = 1'b0;
              if (state_reg == DEV) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  state_next = DEV_ACK;
                  busy_next  = 1'b1;
                  rw_next    = byte_in[0];
                end else begin
                  state_next = WAIT_STOP;
                  busy_next  = 1'b0;
                end
              end else if (state_reg == AHI) begin
                addr_hi_next = byte_in;
                state_next   = AHI_ACK;
              end else if (state_reg == ALO) begin
                ptr_next   = MEM_AW'(word_addr);
                state_next = ALO_ACK;
              end else begin
                mem_we         = 1'b1;
                wr_strobe_next = 1'b1;
                wr_addr_next   = ptr_reg;
                wr_data_next   = byte_in;
                ptr_next       = ptr_reg + PTR_ONE;
                state_next     = WR_ACK;
              end
            end
          end
        end

        // ACK occupies one full scl low-high-low window: drive, then release
        DEV_ACK, AHI_ACK, ALO_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_reg) begin
              sda_drv_next   = 1'b1;
              ack_phase_next = 1'b1;
            end else begin
              sda_drv_next   = 1'b0;
              ack_phase_next = 1'b0;
              bit_cnt_next   = 3'd0;
              if (state_reg == DEV_ACK) begin
                if (rw_reg) begin
                  state_next   = RD;
                  shift_next   = rd_data_reg;
                  sda_drv_next = ~rd_data_reg[7];
                end else begin
                  state_next = bit_ctrl_reg ? AHI : ALO;
                end
              end else if (state_reg == AHI_ACK) begin
                state_next = ALO;
              end else begin
                state_next = WR;
              end
            end
          end
        end

        RD: begin
          if (scl_fall) begin
            if (bit_cnt_reg == 3'd0) begin
              shift_next   = rd_data_reg;
              sda_drv_next = ~rd_data_reg[7];
            end else begin
              shift_next   = {shift_reg[6:0], shift_reg[7]};
              sda_drv_next = ~shift_reg[6];
            end
          end else if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 3'd1;
            if (bit_cnt_reg == 3'd7) begin
              state_next     = RD_ACK;
              ack_phase_next = 1'b0;
            end
          end
        end

        RD_ACK: begin
          if (scl_fall && !ack_phase_reg) begin
            sda_drv_next   = 1'b0;
            ack_phase_next = 1'b1;
          end else if (scl_rise && ack_phase_reg) begin
            ptr_next       = ptr_reg + PTR_ONE;
            ack_phase_next = 1'b0;
            bit_cnt_next   = 3'd0;
            if (!sda_sync) begin
              state_next = RD;
            end else begin
              state_next = WAIT_STOP;
              busy_next  = 1'b0;
            end
          end
        end

        default: begin
          state_next   = IDLE;
          sda_drv_next = 1'b0;
        end
      endcase
    end
  end

  assign sda       = sda_drv_reg ? 1'b0 : 1'bz;
  assign busy      = busy_reg;
  assign wr_strobe = wr_strobe_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bus-level bench for i2c_slave_mem: a bit-banged master issues directed
// transactions while scoreboards check ACKs, read bytes and write strobes.
module tb_i2c_slave_mem;

  localparam int Q = 100;

  logic       clk;
  logic       rst_n;
  logic       scl;
  logic       m_low;
  logic       bit_ctrl;
  logic       busy;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_mem #(.SLAVE_ADDR(7'b101_0000), .MEM_AW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (scl),
    .sda       (sda),
    .bit_ctrl  (bit_ctrl),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      tag;
    logic [7:0] val;
  } item_t;

  item_t       exp_q[$];
  item_t       obs_q[$];
  logic [15:0] exp_wr[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          strobe_cnt = 0;
  logic        dut_low_seen = 1'b0;
  logic        busy_seen = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus scoreboard: ACK bits and read bytes
  initial begin
    forever begin
      @(negedge clk);
      while (obs_q.size() > 0) begin
        item_t o;
        item_t e;
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL %s: got 0x%0h, expected nothing queued", o.tag, o.val);
        end else begin
          e = exp_q.pop_front();
          check(e.tag, {8'h00, o.val}, {8'h00, e.val});
        end
      end
    end
  end

  // Write-strobe scoreboard plus passive bus observers
  initial begin
    forever begin
      @(negedge clk);
      if (sda === 1'b0 && !m_low) dut_low_seen = 1'b1;
      if (busy === 1'b1) busy_seen = 1'b1;
      if (rst_n && wr_strobe) begin
        strobe_cnt++;
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wr_strobe: got addr 0x%0h data 0x%0h, expected no strobe", wr_addr, wr_data);
        end else begin
          check("wr_strobe", {wr_addr, wr_data}, exp_wr.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_start();
    m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
  endtask

  task automatic put_bit(input logic b);
    m_low = !b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    m_low = 1'b0; #Q; scl = 1'b1; #Q; b = (sda === 1'b0) ? 1'b0 : 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_nack, input string tag);
    logic a;
    exp_q.push_back('{tag, {7'd0, exp_nack}});
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    obs_q.push_back('{tag, {7'd0, a}});
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic nack, input string tag);
    logic [7:0] v;
    logic       bb;
    exp_q.push_back('{tag, exp});
    for (int i = 7; i >= 0; i--) begin
      get_bit(bb);
      v[i] = bb;
    end
    obs_q.push_back('{tag, v});
    put_bit(nack);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int snap;
    rst_n    = 1'b0;
    scl      = 1'b1;
    m_low    = 1'b0;
    bit_ctrl = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_busy", {15'd0, busy}, 16'd0);
    check("reset_wr_strobe", {15'd0, wr_strobe}, 16'd0);
    check("reset_wr_addr", {8'd0, wr_addr}, 16'd0);
    check("reset_wr_data", {8'd0, wr_data}, 16'd0);
    check("reset_sda", {15'd0, sda}, 16'd1);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("txn: init write 0x12=0x3C");
    exp_wr.push_back({8'h12, 8'h3C});
    bus_start();
    send_byte(8'hA0, 1'b0, "init_dev_ack");
    send_byte(8'h12, 1'b0, "init_addr_ack");
    send_byte(8'h3C, 1'b0, "init_data_ack");
    bus_stop();
    settle();

    $display("txn: write 0x10 <= 0x5A,0xC3");
    exp_wr.push_back({8'h10, 8'h5A});
    exp_wr.push_back({8'h11, 8'hC3});
    bus_start();
    send_byte(8'hA0, 1'b0, "wr_dev_ack");
    send_byte(8'h10, 1'b0, "wr_addr_ack");
    send_byte(8'h5A, 1'b0, "wr_d0_ack");
    send_byte(8'hC3, 1'b0, "wr_d1_ack");
    @(negedge clk);
    check("busy_during_write", {15'd0, busy}, 16'd1);
    bus_stop();
    settle();
    check("busy_after_stop", {15'd0, busy}, 16'd0);

    $display("txn: random read 0x10 x2 (ACK, NACK)");
    bus_start();
    send_byte(8'hA0, 1'b0, "rr_dev_ack");
    send_byte(8'h10, 1'b0, "rr_addr_ack");
    bus_start();
    send_byte(8'hA1, 1'b0, "rr_devr_ack");
    recv_byte(8'h5A, 1'b0, "rr_byte0");
    recv_byte(8'hC3, 1'b1, "rr_byte1");
    @(negedge clk);
    check("busy_after_nack", {15'd0, busy}, 16'd0);
    check("sda_after_nack", {15'd0, sda}, 16'd1);
    bus_stop();
    settle();

    $display("txn: current-address read (expect mem[0x12])");
    bus_start();
    send_byte(8'hA1, 1'b0, "cur_dev_ack");
    recv_byte(8'h3C, 1'b1, "cur_byte");
    bus_stop();
    settle();

    $display("txn: wrong device address 0xA2");
    dut_low_seen = 1'b0;
    busy_seen    = 1'b0;
    snap         = strobe_cnt;
    bus_start();
    send_byte(8'hA2, 1'b1, "wrong_dev_nack");
    send_byte(8'h00, 1'b1, "wrong_addr_nack");
    bus_stop();
    settle();
    check("wrong_sda_driven", {15'd0, dut_low_seen}, 16'd0);
    check("wrong_busy_seen", {15'd0, busy_seen}, 16'd0);
    check("wrong_strobe_cnt", 16'(strobe_cnt - snap), 16'd0);

    $display("txn: 16-bit write 0x01FF <= 0x11,0x22 (wrap)");
    bit_ctrl = 1'b1;
    exp_wr.push_back({8'hFF, 8'h11});
    exp_wr.push_back({8'h00, 8'h22});
    bus_start();
    send_byte(8'hA0, 1'b0, "w16_dev_ack");
    send_byte(8'h01, 1'b0, "w16_ahi_ack");
    send_byte(8'hFF, 1'b0, "w16_alo_ack");
    send_byte(8'h11, 1'b0, "w16_d0_ack");
    send_byte(8'h22, 1'b0, "w16_d1_ack");
    bus_stop();
    settle();

    $display("txn: 16-bit readback from 0x01FF");
    bus_start();
    send_byte(8'hA0, 1'b0, "r16_dev_ack");
    send_byte(8'h01, 1'b0, "r16_ahi_ack");
    send_byte(8'hFF, 1'b0, "r16_alo_ack");
    bus_start();
    send_byte(8'hA1, 1'b0, "r16_devr_ack");
    recv_byte(8'h11, 1'b0, "r16_byte0");
    recv_byte(8'h22, 1'b1, "r16_byte1");
    bus_stop();
    settle();
    bit_ctrl = 1'b0;

    $display("txn: write 0x31 <= 0xB4");
    exp_wr.push_back({8'h31, 8'hB4});
    bus_start();
    send_byte(8'hA0, 1'b0, "pre_dev_ack");
    send_byte(8'h31, 1'b0, "pre_addr_ack");
    send_byte(8'hB4, 1'b0, "pre_data_ack");
    bus_stop();
    settle();

    $display("txn: write 0x30 <= 0x96 then abort after 4 bits");
    exp_wr.push_back({8'h30, 8'h96});
    bus_start();
    send_byte(8'hA0, 1'b0, "abt_dev_ack");
    send_byte(8'h30, 1'b0, "abt_addr_ack");
    send_byte(8'h96, 1'b0, "abt_data_ack");
    snap = strobe_cnt;
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    bus_stop();
    settle();
    check("abort_strobe_cnt", 16'(strobe_cnt - snap), 16'd0);

    $display("txn: current-address read after abort (expect mem[0x31])");
    bus_start();
    send_byte(8'hA1, 1'b0, "post_dev_ack");
    recv_byte(8'hB4, 1'b1, "post_byte");
    bus_stop();
    settle();

    $display("txn: reset during read while sda driven low");
    bus_start();
    send_byte(8'hA0, 1'b0, "rst_dev_ack");
    send_byte(8'h10, 1'b0, "rst_addr_ack");
    bus_start();
    send_byte(8'hA1, 1'b0, "rst_devr_ack");
    check("rd_bit7_driven_low", {15'd0, sda}, 16'd0);
    rst_n = 1'b0;
    #1;
    check("sda_released_on_reset", {15'd0, sda}, 16'd1);
    check("busy_cleared_on_reset", {15'd0, busy}, 16'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("txn: transaction after reset");
    bus_start();
    send_byte(8'hA0, 1'b0, "after_rst_dev_ack");
    send_byte(8'h10, 1'b0, "after_rst_addr_ack");
    bus_stop();
    settle();

    repeat (20) @(negedge clk);
    check("bus_queue_drained", 16'(exp_q.size()), 16'd0);
    check("wr_queue_drained", 16'(exp_wr.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
